lsu_mem_stage: RTL and testbench

- Load/store unit between the RV32I execute stage and the RAM controller (byte/half/word modes, lane-0 byte enables, 1-cycle read latency, sign extension on its read path).
- Accepts one byte-addressed memory request at a time and checks alignment and range.
- Converts sub-word stores at non-zero offsets into a read-modify-write sequence.
- Extracts and extends sub-word loads, and returns one response per request.

---
 rtl/lsu_mem_stage.sv | 144 ++++++++++++++
 tb/tb_lsu_mem_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// Load/store stage between RV32I execute and the RAM controller.
// One request in flight at a time. Sub-word stores at non-zero offsets become
// a word read, a merge, and a word write. Loads always read a full word and
// select/extend the addressed lane locally.
module lsu_mem_stage #(
  parameter int DEPTH = 4096,
  parameter int XLEN  = 32,
  localparam int ADDRWIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic [XLEN-1:0]      ram_wrData,
  output logic                 ram_wrEn,
  output logic                 ram_byteEn,
  output logic                 ram_halfEn,
  output logic                 ram_wordEn,
  output logic                 ram_unsignedEn,
  input  logic [XLEN-1:0]      ram_dataOut
);
  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, WRITE, RESP} state_t;

  state_t               state, state_n;
  logic [ADDRWIDTH+1:0] addr_q;
  logic [2:0]           f3_q;
  logic                 we_q, err_q;
  logic [XLEN-1:0]      wdata_q, wr_word, rdata_q;

  logic                 req_err, ill_f3, misalign, out_range;
  logic [1:0]           off;
  logic                 rmw;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [XLEN-1:0]      ld_val, merged;

  // Request checks: funct3 legality, natural alignment, and address range.
  always_comb begin
    ill_f3 = 1'b0;
    if (req_we) ill_f3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    else        ill_f3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_range = |req_addr[XLEN-1:ADDRWIDTH+2];
    req_err   = ill_f3 | misalign | out_range;
  end

  // Lane selection for loads and lane merge for read-modify-write stores.
  always_comb begin
    off      = addr_q[1:0];
    rmw      = we_q && (f3_q[1:0] != 2'b10) && (off != 2'b00);
    byte_sel = ram_dataOut[{off, 3'b000} +: 8];
    half_sel = off[1] ? ram_dataOut[31:16] : ram_dataOut[15:0];
    ld_val   = ram_dataOut;
    case (f3_q)
      3'b000:  ld_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_val = {24'd0, byte_sel};
      3'b101:  ld_val = {16'd0, half_sel};
      default: ld_val = ram_dataOut;
    endcase
    merged = ram_dataOut;
    if (f3_q[1:0] == 2'b00) merged[{off, 3'b000} +: 8] = wdata_q[7:0];
    else                    merged[31:16] = wdata_q[15:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and RAM/response drive; defaults give a plain word read.
  always_comb begin
    state_n        = state;
    req_ready      = (state == IDLE);
    rsp_valid      = (state == RESP);
    rsp_err        = (state == RESP) && err_q;
    rsp_rdata      = rdata_q;
    ram_addr       = addr_q[ADDRWIDTH+1:2];
    ram_wrData     = wdata_q;
    ram_wrEn       = 1'b0;
    ram_byteEn     = 1'b0;
    ram_halfEn     = 1'b0;
    ram_wordEn     = 1'b1;
    ram_unsignedEn = 1'b0;
    case (state)
      IDLE:   if (req_valid) state_n = req_err ? RESP : ACCESS;
      ACCESS: begin
        if (we_q && !rmw) begin
          ram_wrEn   = 1'b1;
          ram_byteEn = (f3_q[1:0] == 2'b00);
          ram_halfEn = (f3_q[1:0] == 2'b01);
          ram_wordEn = (f3_q[1:0] == 2'b10);
          state_n    = RESP;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT:   state_n = we_q ? WRITE : RESP;
      WRITE: begin
        ram_wrEn   = 1'b1;
        ram_wrData = wr_word;
        state_n    = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request capture, merged-word latch and load result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      wr_word <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr[ADDRWIDTH+1:0];
        f3_q    <= req_funct3;
        we_q    <= req_we;
        err_q   <= req_err;
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end
      if (state == WAIT) begin
        if (we_q) wr_word <= merged;
        else      rdata_q <= ld_val;
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a behavioural RAM controller model.
module tb_lsu_mem_stage;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wrData, ram_dataOut;
  logic          ram_wrEn, ram_byteEn, ram_halfEn, ram_wordEn, ram_unsignedEn;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:DEPTH-1];
  int          wr_cnt = 0;
  logic [31:0] last_wr = 32'd0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_wrData(ram_wrData), .ram_wrEn(ram_wrEn),
    .ram_byteEn(ram_byteEn), .ram_halfEn(ram_halfEn), .ram_wordEn(ram_wordEn),
    .ram_unsignedEn(ram_unsignedEn), .ram_dataOut(ram_dataOut)
  );

  // RAM controller model: registered read, lane-0 byte/half writes.
  always @(posedge clk) begin
    ram_dataOut <= mem[ram_addr];
    if (ram_wrEn) begin
      if (ram_byteEn)      mem[ram_addr][7:0]  <= ram_wrData[7:0];
      else if (ram_halfEn) mem[ram_addr][15:0] <= ram_wrData[15:0];
      else                 mem[ram_addr]       <= ram_wrData;
      wr_cnt  <= wr_cnt + 1;
      last_wr <= ram_wrData;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one request and check response latency (cycles after accept), err and data.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
    int c, w0;
    c = 0;
    while (!req_ready && c < 20) begin tick(); c++; end
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    w0 = wr_cnt;
    tick();
    req_valid = 1'b0;
    c = 1;
    while (!rsp_valid && c < 10) begin tick(); c++; end
    check({tag, "_lat"}, c, exp_lat);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    if (exp_err) check({tag, "_nowr"}, wr_cnt, w0);
    tick();
  endtask

  initial begin
    int w0, acc, rsp, busy, pend;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
    tick(); tick();
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    check("rst_rdata",     rsp_rdata,          32'd0);
    check("rst_wren",      {31'd0, ram_wrEn},  32'd0);
    check("rst_ready",     {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Word store then load.
    do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0);
    check("mem10", mem[4], 32'hDEADBEEF);
    do_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF);

    // Direct byte store at offset 0 uses lane-0 byte write.
    do_req("sb10", 1'b1, 3'b000, 32'h10, 32'hFFFFFF12, 2, 1'b0, 32'h0);
    check("mem10_sb", mem[4], 32'hDEADBE12);

    // RMW byte store at offset 1.
    do_req("sw20", 1'b1, 3'b010, 32'h20, 32'h11223344, 2, 1'b0, 32'h0);
    do_req("sb21", 1'b1, 3'b000, 32'h21, 32'h000000AA, 4, 1'b0, 32'h0);
    check("sb21_wrdata", last_wr, 32'h1122AA44);
    check("mem20", mem[8], 32'h1122AA44);
    do_req("lbu21", 1'b0, 3'b100, 32'h21, 32'h0, 3, 1'b0, 32'h000000AA);
    do_req("lb21",  1'b0, 3'b000, 32'h21, 32'h0, 3, 1'b0, 32'hFFFFFFAA);

    // RMW half store at offset 2, and halfword loads.
    do_req("sh22", 1'b1, 3'b001, 32'h22, 32'h0000BEEF, 4, 1'b0, 32'h0);
    check("mem20_sh", mem[8], 32'hBEEFAA44);
    do_req("sw30",  1'b1, 3'b010, 32'h30, 32'h80017FFF, 2, 1'b0, 32'h0);
    do_req("lh32",  1'b0, 3'b001, 32'h32, 32'h0, 3, 1'b0, 32'hFFFF8001);
    do_req("lhu32", 1'b0, 3'b101, 32'h32, 32'h0, 3, 1'b0, 32'h00008001);
    do_req("lh30",  1'b0, 3'b001, 32'h30, 32'h0, 3, 1'b0, 32'h00007FFF);
    do_req("lb33",  1'b0, 3'b000, 32'h33, 32'h0, 3, 1'b0, 32'hFFFFFF80);

    // Error cases.
    do_req("lw13_mis",  1'b0, 3'b010, 32'h13, 32'h0, 1, 1'b1, 32'h0);
    do_req("sh31_mis",  1'b1, 3'b001, 32'h31, 32'h1234, 1, 1'b1, 32'h0);
    do_req("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 1'b1, 32'h0);
    do_req("sb_f3_100", 1'b1, 3'b100, 32'h10, 32'h0, 1, 1'b1, 32'h0);
    do_req("sw_range",  1'b1, 3'b010, DEPTH*4, 32'h5A5A5A5A, 1, 1'b1, 32'h0);
    check("mem0_untouched", mem[0], 32'h0);
    do_req("lw_last", 1'b0, 3'b010, DEPTH*4-4, 32'h0, 3, 1'b0, 32'h0);

    // Reset during WAIT of an RMW byte store.
    do_req("sw40", 1'b1, 3'b010, 32'h40, 32'hCAFEBABE, 2, 1'b0, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h42; req_wdata = 32'h55;
    w0 = wr_cnt;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstw_ready",     {31'd0, req_ready}, 32'd1);
    check("rstw_wren",      {31'd0, ram_wrEn},  32'd0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("rstw_nowr", wr_cnt, w0);
    check("rstw_mem40", mem[16], 32'hCAFEBABE);

    // Three back-to-back loads with req_valid held high.
    do_req("sw50", 1'b1, 3'b010, 32'h50, 32'h01020304, 2, 1'b0, 32'h0);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h50;
    acc = 0; rsp = 0; busy = 0; pend = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_valid && req_ready) begin acc++; pend = 1; end
      tick();
      if (acc == 3) req_valid = 1'b0;
      if (pend != 0) begin busy = 1; pend = 0; end
      if (busy != 0) check("b2b_ready_low", {31'd0, req_ready}, 32'd0);
      if (rsp_valid) begin
        rsp++;
        busy = 0;
        check("b2b_rdata", rsp_rdata, 32'h01020304);
      end
    end
    check("b2b_accepts", acc, 3);
    check("b2b_rsps", rsp, 3);
    check("b2b_ready_end", {31'd0, req_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
